// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian words from a framed image,
// writes them into instruction memory, verifies a checksum and then releases the CPU.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    RUN,
    ERR
  } state_t;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] part_q, part_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] len_rx;
  logic        xfer;

  // Status outputs come straight from the state register, so they move one cycle after the deciding handshake.
  assign in_ready  = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
  assign busy      = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
  assign done      = (state_q == RUN);
  assign error     = (state_q == ERR);
  assign cpu_rst   = (state_q != RUN);
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;

  assign xfer   = in_valid && in_ready;
  assign len_rx = {len_hi_q, in_data};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= LEN_HI;
      len_hi_q   <= 8'd0;
      len_q      <= 16'd0;
      byte_idx_q <= 2'd0;
      word_idx_q <= 16'd0;
      csum_q     <= 8'd0;
      part_q     <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wd_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      part_q     <= part_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_hi_d   = len_hi_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    part_d     = part_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;

    unique case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = len_rx;
          if ({1'b0, len_rx} > MaxWords) begin
            state_d = ERR;
          end else if (len_rx == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d     = csum_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: part_d[7:0]   = in_data;
            2'd1: part_d[15:8]  = in_data;
            2'd2: part_d[23:16] = in_data;
            2'd3: begin
              we_d       = 1'b1;
              wd_d       = {in_data, part_q};
              addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              word_idx_d = word_idx_q + 16'd1;
              if (word_idx_q == len_q - 16'd1) begin
                state_d = CHECK;
              end
            end
            default: ;
          endcase
        end
      end
      CHECK: begin
        if (xfer) begin
          state_d = (in_data == csum_q) ? RUN : ERR;
        end
      end
      RUN, ERR: ;
      default: state_d = ERR;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frame table, hand-written reset sequences and
// random frames checked against a frame-level reference model.
module tb_imem_loader;

  localparam int          MAX_WORDS = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;

  logic [7:0]  frameQ[$];
  logic [63:0] expQ[$];
  logic [63:0] gotQ[$];

  typedef struct {
    string        name;
    int           len;
    logic [127:0] bytes;
    bit           gaps;
    bit           expDone;
    bit           expErr;
    int           nW;
    logic [31:0]  a0, d0, a1, d1;
  } vec_t;

  vec_t vecs[6];

  imem_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  // Every write pulse is captured once, at the falling edge in the middle of its cycle.
  always @(negedge CLK) begin
    if (imem_we) gotQ.push_back({imem_addr, imem_wd});
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge CLK);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge CLK);
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1;
    in_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    gotQ.delete();
  endtask

  task automatic checkStatus(input string tag, input bit eDone, input bit eErr);
    bit loading;
    loading = !eDone && !eErr;
    checkOutput({tag, " done"}, 64'(done), 64'(eDone));
    checkOutput({tag, " error"}, 64'(error), 64'(eErr));
    checkOutput({tag, " cpu_rst"}, 64'(cpu_rst), 64'(!eDone));
    checkOutput({tag, " busy"}, 64'(busy), 64'(loading));
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'(loading));
  endtask

  task automatic checkResetState(input string tag);
    checkStatus({tag, " rst"}, 1'b0, 1'b0);
    checkOutput({tag, " rst we"}, 64'(imem_we), 64'd0);
    checkOutput({tag, " rst addr"}, 64'(imem_addr), 64'(BASE_ADDR));
    checkOutput({tag, " rst wd"}, 64'(imem_wd), 64'd0);
  endtask

  // Streams frameQ; also pushes trailing bytes that a finished loader must ignore.
  task automatic sendFrame(input string tag, input bit gaps, input bit eDone, input bit eErr);
    for (int i = 0; i < frameQ.size(); i++) begin
      if (i == frameQ.size() - 1) checkOutput({tag, " pre done"}, 64'(done), 64'd0);
      applyStimulus(frameQ[i], gaps);
    end
    in_valid = 1'b0;
    checkStatus({tag, " end"}, eDone, eErr);
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 1'b0);
    in_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkStatus({tag, " after"}, eDone, eErr);
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, " writes"}, 64'(gotQ.size()), 64'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s w%0d addr", tag, i), 64'(gotQ[i][63:32]), 64'(expQ[i][63:32]));
      checkOutput($sformatf("%s w%0d data", tag, i), 64'(gotQ[i][31:0]), 64'(expQ[i][31:0]));
    end
  endtask

  // Reference: parse the whole frame as a list of bytes.
  task automatic modelFrame(output bit eDone, output bit eErr);
    int n;
    int sum;
    logic [31:0] word;
    expQ.delete();
    eDone = 1'b0;
    eErr  = 1'b0;
    n = int'(frameQ[0]) * 256 + int'(frameQ[1]);
    if (n > MAX_WORDS) begin
      eErr = 1'b1;
      return;
    end
    sum = 0;
    for (int w = 0; w < n; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        word = word | (32'(frameQ[2 + 4*w + k]) << (8*k));
        sum  = sum + int'(frameQ[2 + 4*w + k]);
      end
      expQ.push_back({BASE_ADDR + 32'(4*w), word});
    end
    if (int'(frameQ[2 + 4*n]) == (sum % 256)) eDone = 1'b1;
    else eErr = 1'b1;
  endtask

  task automatic loadVector(input vec_t v);
    frameQ.delete();
    for (int i = 0; i < v.len; i++) frameQ.push_back(8'(v.bytes >> (8*(v.len - 1 - i))));
    expQ.delete();
    if (v.nW > 0) expQ.push_back({v.a0, v.d0});
    if (v.nW > 1) expQ.push_back({v.a1, v.d1});
  endtask

  task automatic loadTest1();
    frameQ = '{8'h00, 8'h02, 8'h05, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h08, 8'hAC, 8'hE1};
    expQ   = '{{32'h0, 32'h2008_0005}, {32'h4, 32'hAC08_0000}};
  endtask

  initial begin
    bit eDone, eErr;
    int n;
    int sum;
    logic [7:0] b;

    vecs[0] = '{"t1",    11, 128'h00_02_05_00_08_20_00_00_08_AC_E1, 1'b0, 1'b1, 1'b0, 2,
                32'h0, 32'h2008_0005, 32'h4, 32'hAC08_0000};
    vecs[1] = '{"t2",    3,  128'h00_00_00, 1'b0, 1'b1, 1'b0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{"t3",    11, 128'h00_02_05_00_08_20_00_00_08_AC_E2, 1'b0, 1'b0, 1'b1, 2,
                32'h0, 32'h2008_0005, 32'h4, 32'hAC08_0000};
    vecs[3] = '{"t4",    2,  128'h01_01, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4] = '{"t5",    11, 128'h00_02_05_00_08_20_00_00_08_AC_E1, 1'b1, 1'b1, 1'b0, 2,
                32'h0, 32'h2008_0005, 32'h4, 32'hAC08_0000};
    vecs[5] = '{"wrap",  7,  128'h00_01_FF_FF_FF_FF_FC, 1'b1, 1'b1, 1'b0, 1,
                32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};

    for (int i = 0; i < 6; i++) begin
      doReset();
      checkResetState(vecs[i].name);
      loadVector(vecs[i]);
      sendFrame(vecs[i].name, vecs[i].gaps, vecs[i].expDone, vecs[i].expErr);
      compareWrites(vecs[i].name);
    end

    // RST asserted while the word-completing 6th byte is on the bus: that byte must not be taken.
    doReset();
    loadTest1();
    for (int i = 0; i < 5; i++) applyStimulus(frameQ[i], 1'b0);
    RST = 1'b1;
    in_data = frameQ[5];
    @(negedge CLK);
    RST = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    checkResetState("t6 midrst");
    checkOutput("t6 partial writes", 64'(gotQ.size()), 64'd0);
    gotQ.delete();
    sendFrame("t6", 1'b0, 1'b1, 1'b0);
    compareWrites("t6");

    // RST from RUN reasserts cpu_rst and returns to awaiting a frame.
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkResetState("runrst");

    // Largest legal image: MAX_WORDS words.
    doReset();
    frameQ.delete();
    frameQ.push_back(8'(MAX_WORDS >> 8));
    frameQ.push_back(8'(MAX_WORDS));
    sum = 0;
    for (int i = 0; i < 4*MAX_WORDS; i++) begin
      b = 8'($urandom);
      sum += int'(b);
      frameQ.push_back(b);
    end
    frameQ.push_back(8'(sum));
    modelFrame(eDone, eErr);
    checkOutput("max model done", 64'(eDone), 64'd1);
    sendFrame("max", 1'b0, 1'b1, 1'b0);
    compareWrites("max");

    // Random frames against the reference model.
    for (int t = 0; t < 25; t++) begin
      doReset();
      frameQ.delete();
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(MAX_WORDS + 1, 65535);
        frameQ.push_back(8'(n >> 8));
        frameQ.push_back(8'(n));
        for (int i = 0; i < 4; i++) frameQ.push_back(8'($urandom));
      end else begin
        n = $urandom_range(0, 6);
        frameQ.push_back(8'(n >> 8));
        frameQ.push_back(8'(n));
        sum = 0;
        for (int i = 0; i < 4*n; i++) begin
          b = 8'($urandom);
          sum += int'(b);
          frameQ.push_back(b);
        end
        b = 8'(sum);
        if ($urandom_range(0, 3) == 0) b = b ^ (8'd1 << $urandom_range(0, 7));
        frameQ.push_back(b);
      end
      modelFrame(eDone, eErr);
      sendFrame($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), eDone, eErr);
      compareWrites($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader; writer side of the instruction memory that the CPU fetch path reads.
- Receives a framed program image over a valid/ready byte interface and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses, verifies an 8-bit checksum, then releases CPU reset.
- Sits between the host/UART byte source and the imem write port; drives the core's RST.

Parameters:
- MAX_WORDS, 256: maximum accepted image length in words; larger lengths are rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be word-aligned.

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous, active-high reset
- in_valid  input  1  byte source has a byte on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready on a CLK edge
- imem_we  output  1  instruction memory write strobe, one-cycle pulse per word
- imem_addr  output  32  byte address of the word being written
- imem_wd  output  32  word being written
- cpu_rst  output  1  reset to CPU core, active-high
- busy  output  1  load in progress (states LEN_HI through CHECK)
- done  output  1  image loaded and verified; CPU running
- error  output  1  load failed; sticky until RST

Behaviour:
- Frame: len_hi, len_lo (16-bit word count N, big-endian), then 4*N data bytes, then checksum byte.
- Data bytes within a word are little-endian: first byte is bits 7:0, fourth byte is bits 31:24.
- Checksum is the mod-256 sum of all data bytes only. Length bytes are excluded.
- Reset: state LEN_HI; in_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wd=0, cpu_rst=1, busy=1, done=0, error=0. Byte index, word index and checksum accumulator are cleared.
- States:
  - LEN_HI -> LEN_LO on handshake.
  - LEN_LO -> (on handshake) ERROR if N>MAX_WORDS; CHECK if N==0; DATA otherwise.
  - DATA: byte counter 0..3. On the 4th byte handshake, imem_we pulses high in the next cycle, with imem_wd = assembled word and imem_addr = BASE_ADDR + 4*word_index. word_index then increments. After word N is accepted -> CHECK.
  - CHECK -> (on handshake) RUN if the byte equals the accumulator, else ERROR.
  - RUN: terminal until RST.
  - ERROR: terminal until RST.
- in_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in RUN and ERROR. in_ready does not depend on in_valid (no combinational path).
- No back-to-back restriction: a byte may be accepted every cycle. Gaps in in_valid stall all counters without losing state.
- imem_addr and imem_wd hold their last written values between pulses.
- Outputs in RUN: cpu_rst=0, done=1, busy=0, registered so they change the cycle after the checksum handshake.
- Outputs in ERROR: cpu_rst=1, error=1, busy=0, done=0.
- Words already written before ERROR are not erased.
- RST mid-load: returns to reset state at the next edge and discards any partial word; no imem_we is issued that cycle.
- RST in RUN: reasserts cpu_rst=1 next cycle and awaits a new frame.
- Counters: word_index is 16 bits; imem_addr arithmetic is 32-bit and wraps silently (unreachable for legal MAX_WORDS).

Test Plan:
1. Stream 00 02 05 00 08 20 00 00 08 AC E1, in_valid continuous -> imem_we pulses at addr 0x0 with wd 0x20080005, then at addr 0x4 with wd 0xAC080000; done=1 and cpu_rst=0 the cycle after E1; in_ready=0 thereafter.
2. Stream 00 00 00 (N=0, checksum 0) -> no imem_we pulses; done=1; cpu_rst=0.
3. Same as test 1 but checksum byte E2 -> both writes occur; error=1; cpu_rst stays 1; further in_valid bytes are ignored (in_ready=0).
4. MAX_WORDS=256, stream 01 01 -> error=1 after the second byte; no imem_we pulses.
5. Test 1 stream with in_valid toggled at random (~50% duty) -> identical writes, addresses and final done.
6. Assert RST for one cycle after the 6th byte of test 1, then send the full test 1 stream -> no write from the partial frame; exactly two writes (addr 0x0, 0x4) from the new frame; done=1.
